mat_seq_ctrl: RTL and testbench

Sequencer and result buffer for a 4x4 matrix product built around the 4-term dot-product stage (A row x B column -> one registered, saturated AB element).
- Holds the A and B operand matrices, which are loaded by a host write port.
- On start, issues the 16 (row, column) operand sets to the dot-product stage one per cycle.
- Captures each returned element into a 16-entry C buffer and pulses done when the last element is stored.

---
 rtl/mat_pkg.sv | 19 +
 rtl/mat_tag_pipe.sv | 38 +++
 rtl/mat_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mat_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
// Shared constants and state encoding for the 4x4 matrix-product sequencer.
package mat_pkg;

  // Matrix dimension and flat element index width ({row[1:0], col[1:0]})
  localparam int unsigned N    = 4;
  localparam int unsigned IdxW = 4;

  // Default operand and result widths
  localparam int unsigned WidthADef   = 9;
  localparam int unsigned WidthBDef   = 8;
  localparam int unsigned WidthSumDef = 11;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } state_e;

endpackage

// File: rtl/mat_tag_pipe.sv
// {valid, index} delay line; an entry pushed at edge E appears on the outputs
// after edge E+Depth-1, so the consumer acts on it at edge E+Depth.
module mat_tag_pipe
  import mat_pkg::*;
#(
  parameter int unsigned Depth  = 2,
  parameter int unsigned IndexW = IdxW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [IndexW-1:0] idx_i,
  output logic              valid_o,
  output logic [IndexW-1:0] idx_o
);

  logic [Depth-1:0]  valid_q;
  logic [IndexW-1:0] idx_q [Depth];

  // Shift register with asynchronous clear of every stage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < int'(Depth); i++) idx_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      idx_q[0]   <= idx_i;
      for (int i = 1; i < int'(Depth); i++) begin
        valid_q[i] <= valid_q[i-1];
        idx_q[i]   <= idx_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[Depth-1];
  assign idx_o   = idx_q[Depth-1];

endmodule

// File: rtl/mat_seq_ctrl.sv
// Sequencer and result buffer for a 4x4 matrix product: holds A and B, issues
// one (row, column) operand set per cycle to the dot-product stage, and stores
// the returned elements into the C buffer.
module mat_seq_ctrl
  import mat_pkg::*;
#(
  parameter int unsigned WIDTH_A_80 = WidthADef,
  parameter int unsigned WIDTH_B_80 = WidthBDef,
  parameter int unsigned WIDTH_SUM  = WidthSumDef,
  parameter int unsigned DP_LATENCY = 1
) (
  input  logic                  clk_80,
  input  logic                  rst_80,
  input  logic                  wr_en_80,
  input  logic                  wr_sel_80,
  input  logic [IdxW-1:0]       wr_addr_80,
  input  logic [WIDTH_A_80-1:0] wr_data_80,
  input  logic                  start_80,
  output logic                  busy_80,
  output logic                  done_80,
  output logic [WIDTH_A_80-1:0] A00_80,
  output logic [WIDTH_A_80-1:0] A01_80,
  output logic [WIDTH_A_80-1:0] A02_80,
  output logic [WIDTH_A_80-1:0] A03_80,
  output logic [WIDTH_B_80-1:0] B00_80,
  output logic [WIDTH_B_80-1:0] B01_80,
  output logic [WIDTH_B_80-1:0] B02_80,
  output logic [WIDTH_B_80-1:0] B03_80,
  input  logic [WIDTH_SUM-1:0]  ab_80,
  input  logic [IdxW-1:0]       rd_addr_80,
  output logic [WIDTH_SUM-1:0]  rd_data_80
);

  localparam int unsigned     Cells   = N * N;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Cells - 1);

  state_e state_q, state_d;

  logic [IdxW-1:0]       k_q;
  logic [WIDTH_A_80-1:0] a_mem   [Cells];
  logic [WIDTH_B_80-1:0] b_mem   [Cells];
  logic [WIDTH_SUM-1:0]  c_mem   [Cells];
  logic [WIDTH_A_80-1:0] a_row_q [N];
  logic [WIDTH_B_80-1:0] b_col_q [N];
  logic                  done_q;
  logic [WIDTH_SUM-1:0]  rd_data_q;

  logic            issue;
  logic            wr_ok;
  logic            tag_valid;
  logic [IdxW-1:0] tag_idx;
  logic            last_capture;

  // Capturing element 15 is the last action of a run
  assign last_capture = tag_valid && (tag_idx == LastIdx);

  // State register
  always_ff @(posedge clk_80 or posedge rst_80) begin
    if (rst_80) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic; start while busy is simply not looked at
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_80) state_d = StIssue;
      StIssue: if (k_q == LastIdx) state_d = StDrain;
      StDrain: if (last_capture) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State-decoded controls
  always_comb begin
    busy_80 = (state_q != StIdle);
    issue   = (state_q == StIssue);
    wr_ok   = wr_en_80 && (state_q == StIdle);
  end

  // Issue counter k; parked at 0 in idle so a run always begins with set 0
  always_ff @(posedge clk_80 or posedge rst_80) begin
    if (rst_80)                k_q <= '0;
    else if (state_q == StIdle) k_q <= '0;
    else if (issue)            k_q <= k_q + 1'b1;
  end

  // Host writes to A/B, accepted only while idle so operands are frozen in a run
  always_ff @(posedge clk_80 or posedge rst_80) begin
    if (rst_80) begin
      for (int i = 0; i < int'(Cells); i++) begin
        a_mem[i] <= '0;
        b_mem[i] <= '0;
      end
    end else if (wr_ok) begin
      if (wr_sel_80) b_mem[wr_addr_80] <= wr_data_80[WIDTH_B_80-1:0];
      else           a_mem[wr_addr_80] <= wr_data_80;
    end
  end

  // Operand registers: row k[3:2] of A and column k[1:0] of B, passed raw
  always_ff @(posedge clk_80 or posedge rst_80) begin
    if (rst_80) begin
      for (int c = 0; c < int'(N); c++) begin
        a_row_q[c] <= '0;
        b_col_q[c] <= '0;
      end
    end else if (issue) begin
      for (int c = 0; c < int'(N); c++) begin
        a_row_q[c] <= a_mem[{k_q[3:2], 2'(c)}];
        b_col_q[c] <= b_mem[{2'(c), k_q[1:0]}];
      end
    end
  end

  // One extra stage beyond the dot-product latency aligns the tag with ab_80
  mat_tag_pipe #(
    .Depth  (DP_LATENCY + 1),
    .IndexW (IdxW)
  ) u_tag_pipe (
    .clk_i   (clk_80),
    .rst_i   (rst_80),
    .valid_i (issue),
    .idx_i   (k_q),
    .valid_o (tag_valid),
    .idx_o   (tag_idx)
  );

  // C buffer capture on valid tags only
  always_ff @(posedge clk_80 or posedge rst_80) begin
    if (rst_80) begin
      for (int i = 0; i < int'(Cells); i++) c_mem[i] <= '0;
    end else if (tag_valid) begin
      c_mem[tag_idx] <= ab_80;
    end
  end

  // Completion pulse and registered C readback
  always_ff @(posedge clk_80 or posedge rst_80) begin
    if (rst_80) begin
      done_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      done_q    <= (state_q == StDrain) && last_capture;
      rd_data_q <= c_mem[rd_addr_80];
    end
  end

  assign done_80    = done_q;
  assign rd_data_80 = rd_data_q;

  assign A00_80 = a_row_q[0];
  assign A01_80 = a_row_q[1];
  assign A02_80 = a_row_q[2];
  assign A03_80 = a_row_q[3];
  assign B00_80 = b_col_q[0];
  assign B01_80 = b_col_q[1];
  assign B02_80 = b_col_q[2];
  assign B03_80 = b_col_q[3];

endmodule

// File: tb/tb_mat_seq_ctrl.sv
// Bench for mat_seq_ctrl: two instances (dot-product latency 1 and 3), each
// with a stub dot stage returning the wrapped sum of all eight operands.
module tb_mat_seq_ctrl;

  localparam int L1 = 1;
  localparam int L3 = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, wr_sel, start1, start3;
  logic [3:0] wr_addr, rd_addr;
  logic [8:0] wr_data;

  logic        busy1, done1, busy3, done3;
  logic [8:0]  a1 [4];
  logic [8:0]  a3 [4];
  logic [7:0]  b1 [4];
  logic [7:0]  b3 [4];
  logic [10:0] ab1, ab3, rd1, rd3, sum1, sum3;
  logic [10:0] p3 [3];

  // Reference state
  logic [8:0]  a_m  [16];
  logic [7:0]  b_m  [16];
  logic [10:0] c1_m [16];
  logic [10:0] c3_m [16];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mat_seq_ctrl #(.DP_LATENCY(L1)) u_dut1 (
    .clk_80(clk), .rst_80(rst), .wr_en_80(wr_en), .wr_sel_80(wr_sel),
    .wr_addr_80(wr_addr), .wr_data_80(wr_data), .start_80(start1),
    .busy_80(busy1), .done_80(done1),
    .A00_80(a1[0]), .A01_80(a1[1]), .A02_80(a1[2]), .A03_80(a1[3]),
    .B00_80(b1[0]), .B01_80(b1[1]), .B02_80(b1[2]), .B03_80(b1[3]),
    .ab_80(ab1), .rd_addr_80(rd_addr), .rd_data_80(rd1)
  );

  mat_seq_ctrl #(.DP_LATENCY(L3)) u_dut3 (
    .clk_80(clk), .rst_80(rst), .wr_en_80(wr_en), .wr_sel_80(wr_sel),
    .wr_addr_80(wr_addr), .wr_data_80(wr_data), .start_80(start3),
    .busy_80(busy3), .done_80(done3),
    .A00_80(a3[0]), .A01_80(a3[1]), .A02_80(a3[2]), .A03_80(a3[3]),
    .B00_80(b3[0]), .B01_80(b3[1]), .B02_80(b3[2]), .B03_80(b3[3]),
    .ab_80(ab3), .rd_addr_80(rd_addr), .rd_data_80(rd3)
  );

  // Stub dot stages
  always_comb begin
    sum1 = 11'(a1[0]) + 11'(a1[1]) + 11'(a1[2]) + 11'(a1[3])
         + 11'(b1[0]) + 11'(b1[1]) + 11'(b1[2]) + 11'(b1[3]);
    sum3 = 11'(a3[0]) + 11'(a3[1]) + 11'(a3[2]) + 11'(a3[3])
         + 11'(b3[0]) + 11'(b3[1]) + 11'(b3[2]) + 11'(b3[3]);
  end

  always @(posedge clk) begin
    ab1   <= sum1;
    p3[0] <= sum3;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign ab3 = p3[2];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  // Element C[idx] as the stub would produce it from the current A/B model
  function automatic logic [10:0] exp_c(input int idx);
    int s;
    s = 0;
    for (int c = 0; c < 4; c++) s += int'(a_m[(idx / 4) * 4 + c]);
    for (int r = 0; r < 4; r++) s += int'(b_m[r * 4 + idx % 4]);
    return 11'(s);
  endfunction

  // Operand set k packed as {A row, B column}
  function automatic logic [127:0] exp_ops(input int k);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) r = (r << 9) | 128'(a_m[(k / 4) * 4 + c]);
    for (int q = 0; q < 4; q++) r = (r << 8) | 128'(b_m[q * 4 + k % 4]);
    return r;
  endfunction

  function automatic logic [127:0] ops1();
    return 128'({a1[0], a1[1], a1[2], a1[3], b1[0], b1[1], b1[2], b1[3]});
  endfunction

  function automatic logic [127:0] ops3();
    return 128'({a3[0], a3[1], a3[2], a3[3], b3[0], b3[1], b3[2], b3[3]});
  endfunction

  task automatic write_op(input logic sel, input logic [3:0] addr, input logic [8:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    if (sel) b_m[addr] = data[7:0];
    else     a_m[addr] = data;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      write_op(1'b0, 4'(i), 9'($urandom_range(0, 511)));
      write_op(1'b1, 4'(i), 9'($urandom_range(0, 511)));
    end
  endtask

  task automatic readback(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      @(negedge clk);
      check($sformatf("%s_rd1_%0d", tag, i), 128'(rd1), 128'(c1_m[i]));
      check($sformatf("%s_rd3_%0d", tag, i), 128'(rd3), 128'(c3_m[i]));
    end
  endtask

  // One run: optional A write in the start cycle, optional start+write poke
  // mid-run, then timing checks on busy/done and operand checks on instance 1
  task automatic run(input string tag, input logic go1, input logic go3, input logic wr,
                     input logic [3:0] waddr, input logic [8:0] wdata, input int poke_n,
                     input int tail);
    int b1n, b3n, d1f, d3f, d1n, d3n;
    logic fin;
    if (wr) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = waddr; wr_data = wdata;
      a_m[waddr] = wdata;
    end
    start1 = go1; start3 = go3;
    @(negedge clk);
    wr_en = 1'b0; start1 = 1'b0; start3 = 1'b0;
    b1n = busy1 ? 1 : 0; b3n = busy3 ? 1 : 0;
    d1f = -1; d3f = -1; d1n = 0; d3n = 0;
    check({tag, "_busy_rise"}, 128'(busy1), 128'(go1));
    fin = 1'b0;
    for (int n = 1; n <= 40 && !fin; n++) begin
      if (poke_n > 0 && n - 1 == poke_n) begin
        start1 = go1; start3 = go3;
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 9'h0FF;
      end else begin
        start1 = 1'b0; start3 = 1'b0; wr_en = 1'b0;
      end
      @(negedge clk);
      if (busy1) b1n++;
      if (busy3) b3n++;
      if (done1) begin d1n++; if (d1f < 0) d1f = n; end
      if (done3) begin d3n++; if (d3f < 0) d3f = n; end
      if (go1 && n <= 16) check($sformatf("%s_ops1_k%0d", tag, n - 1), ops1(), exp_ops(n - 1));
      fin = (!go1 || d1f >= 0) && (!go3 || d3f >= 0);
    end
    start1 = 1'b0; start3 = 1'b0; wr_en = 1'b0;
    repeat (tail) begin
      @(negedge clk);
      if (busy1) b1n++;
      if (busy3) b3n++;
      if (done1) d1n++;
      if (done3) d3n++;
    end
    if (go1) begin
      check({tag, "_done1_edge"}, 128'(d1f), 128'(17 + L1));
      check({tag, "_done1_count"}, 128'(d1n), 128'(1));
      check({tag, "_busy1_cycles"}, 128'(b1n), 128'(17 + L1));
      for (int i = 0; i < 16; i++) c1_m[i] = exp_c(i);
    end
    if (go3) begin
      check({tag, "_done3_edge"}, 128'(d3f), 128'(17 + L3));
      check({tag, "_done3_count"}, 128'(d3n), 128'(1));
      check({tag, "_busy3_cycles"}, 128'(b3n), 128'(17 + L3));
      for (int i = 0; i < 16; i++) c3_m[i] = exp_c(i);
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    start1 = 1'b0; start3 = 1'b0; rd_addr = '0;
    for (int i = 0; i < 16; i++) begin
      a_m[i] = '0; b_m[i] = '0; c1_m[i] = '0; c3_m[i] = '0;
    end
    repeat (2) @(negedge clk);
    check("reset_busy1", 128'(busy1), 128'(0));
    check("reset_done1", 128'(done1), 128'(0));
    check("reset_ops1", ops1(), 128'(0));
    check("reset_rd1", 128'(rd1), 128'(0));
    check("reset_busy3", 128'(busy3), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // A[i][0] = i, B[0][j] = 16*j
    for (int i = 0; i < 4; i++) write_op(1'b0, 4'(i * 4), 9'(i));
    for (int j = 0; j < 4; j++) write_op(1'b1, 4'(j), 9'(16 * j));
    run("plan", 1'b1, 1'b1, 1'b0, 4'd0, 9'd0, -1, 3);
    readback("plan");

    // Start pulse and A[0][0] write mid-run must both be ignored
    fill_random();
    run("poke", 1'b1, 1'b1, 1'b0, 4'd0, 9'd0, 5, 4);
    readback("poke");

    // Same-cycle write and start, then a back-to-back run that rewrites C
    run("samecyc", 1'b1, 1'b0, 1'b1, 4'd0, 9'h100, -1, 0);
    run("b2b", 1'b1, 1'b0, 1'b1, 4'd6, 9'($urandom_range(0, 511)), -1, 3);
    readback("b2b");

    for (int it = 0; it < 3; it++) begin
      fill_random();
      run($sformatf("rand%0d", it), 1'b1, 1'b1, 1'b0, 4'd0, 9'd0, -1, 2);
      readback($sformatf("rand%0d", it));
    end

    // Reset in the middle of a run
    start1 = 1'b1; start3 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy1", 128'(busy1), 128'(0));
    check("midrst_done1", 128'(done1), 128'(0));
    check("midrst_ops1", ops1(), 128'(0));
    check("midrst_busy3", 128'(busy3), 128'(0));
    check("midrst_ops3", ops3(), 128'(0));
    check("midrst_rd1", 128'(rd1), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a_m[i] = '0; b_m[i] = '0; c1_m[i] = '0; c3_m[i] = '0;
    end
    readback("postrst");
    check("postrst_done1", 128'(done1), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
